// File: rtl/vga_sync_decoder_if.sv
// Video timing bus from a VGA timing source: pixel enable, active-low syncs and
// the visible-pixel flag. The source drives the master side; the decoder listens.
interface vga_sync_decoder_if;
  logic pix_en;
  logic hs;
  logic vs;
  logic bright;

  modport master (output pix_en, hs, vs, bright);
  modport slave  (input  pix_en, hs, vs, bright);
endinterface

// File: rtl/vga_sync_decoder.sv
// Decodes a VGA hs/vs/bright stream into pixel coordinates, measures line and
// frame periods, and tracks lock against the nominal H_TOTAL x V_TOTAL geometry.
module vga_sync_decoder #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  vga_sync_decoder_if.slave     vid,
  output logic [9:0]            x,
  output logic [9:0]            y,
  output logic                  active,
  output logic                  frame_start,
  output logic                  locked,
  output logic [10:0]           line_len,
  output logic [9:0]            frame_lines,
  output logic [15:0]           err_count
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_e;

  state_e      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  x_next_q, x_next_d;
  logic [9:0]  y_q, y_d;
  logic        line_bright_q, line_bright_d;
  logic        active_q, active_d;
  logic        frame_start_q, frame_start_d;
  logic        hs_seen_q, hs_seen_d;
  logic        vs_seen_q, vs_seen_d;
  logic        frame_ok_q, frame_ok_d;
  logic [15:0] good_cnt_q, good_cnt_d;
  logic [15:0] err_count_q, err_count_d;

  logic        hs_fall;
  logic        vs_fall;
  logic [10:0] line_meas;
  logic [9:0]  frame_meas;
  logic        line_bad;
  logic        frame_good;
  logic [9:0]  x_base;

  assign hs_fall    = vid.pix_en & hs_prev_q & ~vid.hs;
  assign vs_fall    = vid.pix_en & vs_prev_q & ~vid.vs;
  assign line_meas  = (hcnt_q == 11'h7FF) ? 11'h7FF : hcnt_q + 11'd1;
  assign frame_meas = (vcnt_q == 10'h3FF) ? 10'h3FF : vcnt_q + 10'd1;

  // The first line after reset starts at an unknown point, so it is never judged.
  assign line_bad   = hs_fall & hs_seen_q & (line_meas != 11'(H_TOTAL));
  assign frame_good = (frame_meas == 10'(V_TOTAL)) & frame_ok_q & ~line_bad;
  assign x_base     = hs_fall ? 10'd0 : x_next_q;

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    x_d           = x_q;
    x_next_d      = x_next_q;
    y_d           = y_q;
    line_bright_d = line_bright_q;
    active_d      = active_q;
    frame_start_d = 1'b0;
    hs_seen_d     = hs_seen_q;
    vs_seen_d     = vs_seen_q;
    frame_ok_d    = frame_ok_q;
    good_cnt_d    = good_cnt_q;
    err_count_d   = err_count_q;

    if (vid.pix_en) begin
      hs_prev_d = vid.hs;
      vs_prev_d = vid.vs;
      active_d  = vid.bright;

      if (hs_fall) begin
        hcnt_d     = 11'd0;
        line_len_d = line_meas;
        hs_seen_d  = 1'b1;
      end else if (hcnt_q != 11'h7FF) begin
        hcnt_d = hcnt_q + 11'd1;
      end

      // A coincident vs_fall wins over the hs_fall line increment.
      if (vs_fall) begin
        vcnt_d        = 10'd0;
        frame_lines_d = frame_meas;
        frame_start_d = 1'b1;
        vs_seen_d     = 1'b1;
        frame_ok_d    = 1'b1;
      end else begin
        if (hs_fall && vcnt_q != 10'h3FF) vcnt_d = vcnt_q + 10'd1;
        if (line_bad) frame_ok_d = 1'b0;
      end

      if (vid.bright) begin
        x_d      = x_base;
        x_next_d = (x_base == 10'h3FF) ? x_base : x_base + 10'd1;
      end else begin
        x_next_d = x_base;
        if (hs_fall) x_d = 10'd0;
      end

      // y advances only past lines that actually carried visible pixels.
      line_bright_d = hs_fall ? vid.bright : (line_bright_q | vid.bright);
      if (vs_fall) begin
        y_d = 10'd0;
      end else if (hs_fall && line_bright_q && y_q != 10'h3FF) begin
        y_d = y_q + 10'd1;
      end

      case (state_q)
        SEARCH: begin
          if (vs_fall) begin
            state_d    = MEASURE;
            good_cnt_d = 16'd0;
          end
        end
        MEASURE: begin
          if (vs_fall) begin
            if (vs_seen_q && frame_good) begin
              good_cnt_d = good_cnt_q + 16'd1;
              if (good_cnt_q + 16'd1 >= 16'(LOCK_FRAMES)) state_d = LOCKED;
            end else begin
              good_cnt_d = 16'd0;
            end
          end
        end
        LOCKED: begin
          if (line_bad || (vs_fall && vs_seen_q && !frame_good)) begin
            state_d = SEARCH;
            if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      hcnt_q        <= 11'd0;
      vcnt_q        <= 10'd0;
      line_len_q    <= 11'd0;
      frame_lines_q <= 10'd0;
      x_q           <= 10'd0;
      x_next_q      <= 10'd0;
      y_q           <= 10'd0;
      line_bright_q <= 1'b0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      hs_seen_q     <= 1'b0;
      vs_seen_q     <= 1'b0;
      frame_ok_q    <= 1'b1;
      good_cnt_q    <= 16'd0;
      err_count_q   <= 16'd0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      x_q           <= x_d;
      x_next_q      <= x_next_d;
      y_q           <= y_d;
      line_bright_q <= line_bright_d;
      active_q      <= active_d;
      frame_start_q <= frame_start_d;
      hs_seen_q     <= hs_seen_d;
      vs_seen_q     <= vs_seen_d;
      frame_ok_q    <= frame_ok_d;
      good_cnt_q    <= good_cnt_d;
      err_count_q   <= err_count_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == LOCKED);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_count_q;

endmodule

// File: doc/vga_sync_decoder.md
VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 Parameter V_TOTAL, default 525, lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive good frames required to declare lock.
REQ-004 Port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 Port reset_n, input, 1, asynchronous active-low reset.
REQ-006 Port pix_en, input, 1, pixel-clock enable, one clk cycle per pixel.
REQ-007 Port hs, input, 1, horizontal sync, active-low.
REQ-008 Port vs, input, 1, vertical sync, active-low.
REQ-009 Port bright, input, 1, active-video flag, high = visible pixel.
REQ-010 Port x, output, 10, active pixel column of current sample.
REQ-011 Port y, output, 10, active line row of current sample.
REQ-012 Port active, output, 1, registered copy of bright, aligned with x/y.
REQ-013 Port frame_start, output, 1, one-clk pulse on each detected vs falling edge.
REQ-014 Port locked, output, 1, high while in LOCKED state.
REQ-015 Port line_len, output, 11, last measured hs-to-hs period in pixels.
REQ-016 Port frame_lines, output, 10, last measured vs-to-vs period in lines.
REQ-017 Port err_count, output, 16, loss-of-lock event count, saturating at 16'hFFFF, for the seven-segment driver.

Function
REQ-018 hs, vs, bright SHALL be sampled only on clk edges with pix_en=1; with pix_en=0 all state SHALL hold.
REQ-019 hs_fall / vs_fall SHALL be defined as previous sample 1, current sample 0.
REQ-020 Pixel counter hcnt (11 bit) SHALL clear to 0 on hs_fall, else increment, saturating at 2047.
REQ-021 On hs_fall, line_len SHALL load hcnt+1 (saturating at 2047); one-sample latency.
REQ-022 Line counter vcnt (10 bit) SHALL increment on hs_fall, clear to 0 on vs_fall, saturate at 1023.
REQ-023 On vs_fall, frame_lines SHALL load vcnt+1 (saturating); frame_start SHALL pulse in the same cycle.
REQ-024 vs_fall and hs_fall on the same sample: vs_fall clears vcnt; hs_fall still updates hcnt and line_len.
REQ-025 x SHALL present the index of the current bright pixel within the line (0 at first bright sample), clearing on hs_fall; x SHALL hold its last value while bright=0.
REQ-026 y SHALL increment on hs_fall only if the preceding line contained at least one bright sample; y SHALL clear to 0 on vs_fall.
REQ-027 x, y, active SHALL be registered, valid one clk after the sampling pix_en edge.
REQ-028 A line is good when line_len equals H_TOTAL; a frame is good when frame_lines equals V_TOTAL and every line in it was good.
REQ-029 FSM states: SEARCH, MEASURE, LOCKED.
REQ-030 SEARCH -> MEASURE on first vs_fall; good-frame counter cleared.
REQ-031 MEASURE: each good frame increments the good-frame counter; a bad frame clears it; reaching LOCK_FRAMES -> LOCKED at that vs_fall.
REQ-032 LOCKED -> SEARCH on any bad line (checked at hs_fall) or bad frame (checked at vs_fall); err_count increments once per exit.
REQ-033 A measurement that completes on the first hs_fall or vs_fall after reset (previous edge unknown) SHALL NOT be judged.

Reset
REQ-034 While reset_n=0: x=0, y=0, active=0, frame_start=0, locked=0, line_len=0, frame_lines=0, err_count=0, state SEARCH, hcnt=vcnt=0, previous hs/vs samples=1.
REQ-035 Assertion mid-frame SHALL take effect immediately; release SHALL require a new vs_fall before leaving SEARCH.

Verification
REQ-036 Standard 640x480 timing (800x525, pix_en every 4th clk), 3 frames -> locked rises at 3rd vs_fall (2 good frames after the MEASURE entry), line_len=800, frame_lines=525, err_count=0.
REQ-037 Locked, then one line shortened to 799 pixels -> locked falls at that hs_fall, err_count=1, state SEARCH, relock after 2 more good frames.
REQ-038 First visible pixel of frame -> x=0, y=0, active=1; last visible pixel -> x=639, y=479.
REQ-039 hs held low for 3000 pixels -> hcnt saturates at 2047, line_len=2047 on next hs_fall, no wrap.
REQ-040 reset_n pulsed low mid-line while locked -> all outputs zero within same cycle, err_count=0, locked stays 0 until 2 good frames after next vs_fall.
REQ-041 pix_en held low 100 clks mid-line with toggling hs -> no counter, x, y, or state change.
